// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU blocks:
//   - 3-bit opcode encodings understood by every ALU datapath
//   - FSM state encoding of the serial ALU controller
// No ports; imported with "import alu_pkg::*;".
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_PASS_A = 3'b000;
    localparam logic [OP_W-1:0] OP_PASS_B = 3'b001;
    localparam logic [OP_W-1:0] OP_NOT_A  = 3'b010;
    localparam logic [OP_W-1:0] OP_NOT_B  = 3'b011;
    localparam logic [OP_W-1:0] OP_AND    = 3'b100;
    localparam logic [OP_W-1:0] OP_OR     = 3'b101;
    localparam logic [OP_W-1:0] OP_XOR    = 3'b110;
    localparam logic [OP_W-1:0] OP_ADD    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_t;

endpackage : alu_pkg

// File: rtl/serial_alu_ctrl_if.sv
// ----------------------------------------------------------------------------
// serial_alu_ctrl_if
// Request/response bundle of the bit-serial ALU.
//   Request  : in_valid, in_ready, op[2:0], a[WIDTH-1:0], b[WIDTH-1:0], cin
//   Response : out_valid, out_ready, result[WIDTH-1:0], cout
// Modports:
//   master - requester/consumer side (drives the request, takes the result)
//   slave  - the ALU controller
// ----------------------------------------------------------------------------
interface serial_alu_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, result, cout
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, result, cout
    );
endinterface : serial_alu_ctrl_if

// File: rtl/alu_bit_slice.sv
// ----------------------------------------------------------------------------
// alu_bit_slice
// Purely combinational one-bit ALU slice.
//   a, b  : operand bits
//   op    : opcode (alu_pkg OP_*)
//   cin   : carry into this bit (only meaningful for OP_ADD)
//   c     : result bit
//   cout  : carry out; majority(a,b,cin) for OP_ADD, 0 for every other op
// ----------------------------------------------------------------------------
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic            a,
    input  logic            b,
    input  logic [OP_W-1:0] op,
    input  logic            cin,
    output logic            c,
    output logic            cout
);

    always_comb begin
        c    = 1'b0;
        cout = 1'b0;
        case (op)
            OP_PASS_A: c = a;
            OP_PASS_B: c = b;
            OP_NOT_A:  c = ~a;
            OP_NOT_B:  c = ~b;
            OP_AND:    c = a & b;
            OP_OR:     c = a | b;
            OP_XOR:    c = a ^ b;
            OP_ADD: begin
                c    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            default: begin
                c    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule : alu_bit_slice

// File: rtl/serial_alu_ctrl.sv
// ----------------------------------------------------------------------------
// serial_alu_ctrl
// Bit-serial ALU: accepts one operation in IDLE, processes it LSB first at one
// bit per clock in RUN, then presents result/cout in DONE until consumed.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_alu_ctrl_if.slave (in_valid/in_ready/op/a/b/cin request,
//           out_valid/out_ready/result/cout response)
// Parameter WIDTH (>= 2) must match the WIDTH of the connected interface.
// ----------------------------------------------------------------------------
module serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    serial_alu_ctrl_if.slave bus
);

    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    alu_state_t       r_state;
    alu_state_t       w_next_state;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_last_bit;

    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OP_W-1:0]  r_op;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;

    logic             w_slice_c;
    logic             w_slice_cout;

    assign w_accept   = w_in_ready && bus.in_valid;
    assign w_last_bit = (r_idx == LAST_IDX);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last_bit) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                // Returning to IDLE here; in_ready is low this cycle, so no
                // new request can be taken on the same edge.
                if (bus.out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand/result shift registers, carry and bit index.
    // Operands shift right so bit 0 always feeds the slice; result bits enter
    // at the MSB so after WIDTH shifts the first processed bit sits at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_PASS_A;
            r_carry  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_idx    <= '0;
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_op     <= bus.op;
            r_carry  <= bus.cin;
        end else if (r_state == ST_RUN) begin
            r_idx    <= r_idx + 1'b1;
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_carry  <= w_slice_cout;
            r_result <= {w_slice_c, r_result[WIDTH-1:1]};
        end
    end

    alu_bit_slice u_bit_slice (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .op   (r_op),
        .cin  (r_carry),
        .c    (w_slice_c),
        .cout (w_slice_cout)
    );

    // Non-add ops clear the carry on every bit, so r_carry is 0 in DONE.
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.cout      = r_carry;

endmodule : serial_alu_ctrl
